// File: rtl/dmem_sensor_arbiter.sv
// Purpose : shares single-port DMEM between the core (strict priority) and a buffered sensor write path.
// Latency : core access is combinational pass-through; a sensor write reaches DMEM one cycle after push at the earliest.
// Backpres: sns_ready drops when the write FIFO is full; the core is never stalled.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   core_en/we/addr/wdata       core DMEM request (always wins the port)
//   core_rdata                  load data: youngest live FIFO entry on a word match, else mem_rdata
//   sns_valid/ready/addr/wdata  sensor write request into the FIFO
//   mem_en/we/addr/wdata/rdata  single-port DMEM interface
//   fifo_level                  registered occupancy
//   starve                      registered: drain blocked by the core for STARVE_LIMIT cycles
//   drain_count                 registered, wrapping count of DMEM writes issued from the FIFO
module dmem_sensor_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_en,
    input  logic                     core_we,
    input  logic [31:0]              core_addr,
    input  logic [31:0]              core_wdata,
    output logic [31:0]              core_rdata,
    input  logic                     sns_valid,
    output logic                     sns_ready,
    input  logic [31:0]              sns_addr,
    input  logic [31:0]              sns_wdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     starve,
    output logic [15:0]              drain_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef logic [PW-1:0] ptr_t;

    // Entry storage. Entries are written at the tail and retired at the head;
    // a kill bit lets a newer core store neutralise a stale pending write
    // without disturbing FIFO order.
    logic [31:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_kill;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] kill_nxt;
    logic [DEPTH-1:0] kill_vec;

    ptr_t             head_ptr;
    ptr_t             tail_ptr;
    logic [CW-1:0]    wait_cnt;
    logic [CW-1:0]    wait_cnt_nxt;

    logic             fifo_empty;
    logic             fifo_full;
    logic             head_live;
    logic             do_pop;
    logic             do_drain;
    logic             do_push;
    logic             core_store;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    ptr_t             fwd_idx;

    // ------------------------------------------------------------------
    // Occupancy and handshake
    // ------------------------------------------------------------------
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LW'(DEPTH));
    assign head_live  = ent_vld[head_ptr] && !ent_kill[head_ptr];

    // Ready looks at the stored level only, so a full FIFO refuses a push
    // even in a cycle where the head is being retired.
    assign sns_ready  = !fifo_full && !reset;
    assign do_push    = sns_valid && sns_ready;

    // The port is ours only when the core leaves it idle. A killed head is
    // still retired in that slot, just without touching DMEM.
    assign do_pop     = !reset && !core_en && !fifo_empty;
    assign do_drain   = do_pop && head_live;
    assign core_store = !reset && core_en && core_we;

    // ------------------------------------------------------------------
    // DMEM port mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (core_en) begin
                mem_en    = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end else if (do_drain) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ent_addr[head_ptr];
                mem_wdata = ent_data[head_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load forwarding: walk entries from oldest to youngest so the last
    // match seen is the youngest. Only stored entries take part; a write
    // being pushed this cycle is not yet visible.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_ptr + ptr_t'(i);
            if (ent_vld[fwd_idx] && !ent_kill[fwd_idx] &&
                (ent_addr[fwd_idx][31:2] == core_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

    assign core_rdata = fwd_hit ? fwd_data : mem_rdata;

    // ------------------------------------------------------------------
    // Store kill: a core store supersedes every pending entry for the same
    // word. The slot being pushed this cycle is not yet valid, so it is
    // never in kill_vec and the sensor write stays the newer one.
    // ------------------------------------------------------------------
    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_vec[i] = core_store && ent_vld[i] &&
                          (ent_addr[i][31:2] == core_addr[31:2]);
        end
    end

    // Push and pop never target the same slot: that would need head==tail
    // with both allowed, i.e. a FIFO that is simultaneously empty and full.
    always_comb begin
        vld_nxt  = ent_vld;
        kill_nxt = ent_kill | kill_vec;
        if (do_pop) begin
            vld_nxt[head_ptr]  = 1'b0;
            kill_nxt[head_ptr] = 1'b0;
        end
        if (do_push) begin
            vld_nxt[tail_ptr]  = 1'b1;
            kill_nxt[tail_ptr] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking: counts cycles a non-empty FIFO is locked out by
    // the core; any retirement or an empty FIFO restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (do_pop || fifo_empty) begin
            wait_cnt_nxt = '0;
        end else if (core_en && (wait_cnt != CW'(STARVE_LIMIT))) begin
            wait_cnt_nxt = wait_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            fifo_level  <= '0;
            ent_vld     <= '0;
            ent_kill    <= '0;
            wait_cnt    <= '0;
            starve      <= 1'b0;
            drain_count <= '0;
        end else begin
            ent_vld  <= vld_nxt;
            ent_kill <= kill_nxt;
            if (do_push) begin
                tail_ptr <= tail_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + ptr_t'(1);
            end
            if (do_push && !do_pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (!do_push && do_pop) begin
                fifo_level <= fifo_level - LW'(1);
            end
            wait_cnt <= wait_cnt_nxt;
            starve   <= (wait_cnt_nxt == CW'(STARVE_LIMIT));
            if (do_drain) begin
                drain_count <= drain_count + 16'd1;
            end
        end
    end

    // Payload needs no reset: the valid bits decide whether it is looked at.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_addr[tail_ptr] <= sns_addr;
            ent_data[tail_ptr] <= sns_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_sensor_arbiter.sv
// Purpose : directed, table-driven check of dmem_sensor_arbiter with a behavioural DMEM.
// Latency : inputs change 1 time unit after posedge, outputs sampled at negedge.
// Backpres: sensor stimulus holds a request until the bench expects it to be accepted.
module tb_dmem_sensor_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_en;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        sns_valid;
    logic        sns_ready;
    logic [31:0] sns_addr;
    logic [31:0] sns_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  fifo_level;
    logic        starve;
    logic [15:0] drain_count;
    logic        tb_init;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_sensor_arbiter #(.DEPTH(4), .STARVE_LIMIT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_en     (core_en),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .sns_valid   (sns_valid),
        .sns_ready   (sns_ready),
        .sns_addr    (sns_addr),
        .sns_wdata   (sns_wdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fifo_level  (fifo_level),
        .starve      (starve),
        .drain_count (drain_count)
    );

    // Behavioural DMEM: combinational read, write at posedge.
    logic [31:0] dmem [0:1023];

    function automatic logic [31:0] pre(input int i);
        return (i == 'h80) ? 32'h0 : (32'hD000_0000 | 32'(i));
    endfunction

    assign mem_rdata = dmem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= pre(i);
        end else if (mem_en && mem_we) begin
            dmem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] ce, we, ca, cd;
        logic [31:0] sv, sa, sd;
        logic [31:0] e_en, e_we, e_addr, e_wdata, e_rdata, e_rdy, e_lvl, e_drn;
    } vec_t;

    vec_t vq[$];

    int   t2_lvl [11] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 2, 1};
    int   t2_rdy [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] ce, we, ca, cd, sv, sa, sd,
                       input logic [31:0] e_en, e_we, e_addr, e_wdata, e_rdata, e_rdy, e_lvl, e_drn);
        vec_t v;
        v.ce = ce; v.we = we; v.ca = ca; v.cd = cd;
        v.sv = sv; v.sa = sa; v.sd = sd;
        v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_rdata = e_rdata; v.e_rdy = e_rdy; v.e_lvl = e_lvl; v.e_drn = e_drn;
        vq.push_back(v);
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] ca, input logic [31:0] cd,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd);
        core_en    = ce;
        core_we    = we;
        core_addr  = ca;
        core_wdata = cd;
        sns_valid  = sv;
        sns_addr   = sa;
        sns_wdata  = sd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        //  ce we  caddr  cdata  sv saddr  sdata   en we  maddr  mwdata  rdata         rdy lvl drn
        // Back-to-back sensor writes with the core idle
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 0, 0);
        add(0, 0, 0,     0,     1, 'h100, 'hA,    0, 0, 0,     0,      0,            1, 0, 0);
        add(0, 0, 0,     0,     1, 'h104, 'hB,    1, 1, 'h100, 'hA,    0,            1, 1, 0);
        add(0, 0, 0,     0,     1, 'h108, 'hC,    1, 1, 'h104, 'hB,    0,            1, 1, 1);
        add(0, 0, 0,     0,     0, 0,     0,      1, 1, 'h108, 'hC,    0,            1, 1, 2);
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 0, 3);
        // Forwarding: two writes to 0x200 queued behind a busy core
        add(1, 0, 'h400, 0,     1, 'h200, 'h11,   1, 0, 'h400, 0,      'hD0000100,   1, 0, 3);
        add(1, 0, 'h200, 0,     1, 'h200, 'h22,   1, 0, 'h200, 0,      'h11,         1, 1, 3);
        add(1, 0, 'h200, 0,     0, 0,     0,      1, 0, 'h200, 0,      'h22,         1, 2, 3);
        add(1, 0, 'h204, 0,     0, 0,     0,      1, 0, 'h204, 0,      'hD0000081,   1, 2, 3);
        add(1, 0, 'h202, 0,     0, 0,     0,      1, 0, 'h202, 0,      'h22,         1, 2, 3);
        add(0, 0, 0,     0,     0, 0,     0,      1, 1, 'h200, 'h11,   0,            1, 2, 3);
        add(0, 0, 0,     0,     0, 0,     0,      1, 1, 'h200, 'h22,   0,            1, 1, 4);
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 0, 5);
        // Kill: core store to 0x300 supersedes the queued sensor write
        add(1, 1, 'h500, 'h77,  1, 'h300, 'h1,    1, 1, 'h500, 'h77,   0,            1, 0, 5);
        add(1, 1, 'h300, 'h9,   0, 0,     0,      1, 1, 'h300, 'h9,    0,            1, 1, 5);
        add(1, 0, 'h300, 0,     0, 0,     0,      1, 0, 'h300, 0,      'h9,          1, 1, 5);
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 1, 5);
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 0, 5);
        // Push in the same cycle as a matching core store survives
        add(1, 1, 'h304, 'h33,  1, 'h304, 'h44,   1, 1, 'h304, 'h33,   0,            1, 0, 5);
        add(1, 0, 'h304, 0,     0, 0,     0,      1, 0, 'h304, 0,      'h44,         1, 1, 5);
        add(0, 0, 0,     0,     0, 0,     0,      1, 1, 'h304, 'h44,   0,            1, 1, 5);
        add(0, 0, 0,     0,     0, 0,     0,      0, 0, 0,     0,      0,            1, 0, 6);

        // Reset with requests on both sides: nothing may reach DMEM.
        reset   = 1'b1;
        tb_init = 1'b1;
        drive(1'b1, 1'b1, 32'h40, 32'h5, 1'b1, 32'h100, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 tb_init = 1'b0;
        @(negedge clk);
        check("reset mem_en",      32'(mem_en),      32'h0);
        check("reset sns_ready",   32'(sns_ready),   32'h0);
        check("reset fifo_level",  32'(fifo_level),  32'h0);
        check("reset drain_count", 32'(drain_count), 32'h0);
        check("reset starve",      32'(starve),      32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            drive(vq[i].ce[0], vq[i].we[0], vq[i].ca, vq[i].cd, vq[i].sv[0], vq[i].sa, vq[i].sd);
            @(negedge clk);
            check($sformatf("row%0d mem_en", i),      32'(mem_en),      vq[i].e_en);
            check($sformatf("row%0d mem_we", i),      32'(mem_we),      vq[i].e_we);
            check($sformatf("row%0d mem_addr", i),    mem_addr,         vq[i].e_addr);
            check($sformatf("row%0d mem_wdata", i),   mem_wdata,        vq[i].e_wdata);
            check($sformatf("row%0d sns_ready", i),   32'(sns_ready),   vq[i].e_rdy);
            check($sformatf("row%0d fifo_level", i),  32'(fifo_level),  vq[i].e_lvl);
            check($sformatf("row%0d drain_count", i), 32'(drain_count), vq[i].e_drn);
            if (vq[i].ce[0] && !vq[i].we[0])
                check($sformatf("row%0d core_rdata", i), core_rdata, vq[i].e_rdata);
        end
        check("dmem 0x100", dmem[10'h040], 32'hA);
        check("dmem 0x104", dmem[10'h041], 32'hB);
        check("dmem 0x108", dmem[10'h042], 32'hC);
        check("dmem 0x200", dmem[10'h080], 32'h22);
        check("dmem 0x300", dmem[10'h0C0], 32'h9);
        check("dmem 0x304", dmem[10'h0C1], 32'h44);

        // Fill while the core is busy, then drain once it goes idle.
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            drive(c < 6, 1'b0, 32'h800, 32'h0, k < 5, 32'h600 + 32'(4 * k), 32'h60 + 32'(k));
            @(negedge clk);
            if (c < 11) begin
                check($sformatf("fill c%0d sns_ready", c),  32'(sns_ready),  32'(t2_rdy[c]));
                check($sformatf("fill c%0d fifo_level", c), 32'(fifo_level), 32'(t2_lvl[c]));
                if (c >= 6) begin
                    check($sformatf("fill c%0d mem_we", c),    32'(mem_we), 32'h1);
                    check($sformatf("fill c%0d mem_addr", c),  mem_addr,    32'h600 + 32'(4 * (c - 6)));
                    check($sformatf("fill c%0d mem_wdata", c), mem_wdata,   32'h60 + 32'(c - 6));
                end else begin
                    check($sformatf("fill c%0d mem_we", c),    32'(mem_we), 32'h0);
                end
                if (k < 5 && t2_rdy[c] == 1) k++;
            end else begin
                check("fill end mem_en",      32'(mem_en),      32'h0);
                check("fill end fifo_level",  32'(fifo_level),  32'h0);
                check("fill end drain_count", 32'(drain_count), 32'd11);
            end
        end

        // Starvation: one entry locked out for 20 cycles.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 32'h700, 32'h70);
        @(negedge clk);
        check("starve c0", 32'(starve), 32'h0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("starve c%0d", c),       32'(starve),     32'(c >= 17));
            check($sformatf("starve c%0d level", c), 32'(fifo_level), 32'h1);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("starve pop cycle",   32'(starve), 32'h1);
        check("starve pop mem_en",  32'(mem_en), 32'h1);
        check("starve pop mem_addr", mem_addr,   32'h700);
        check("starve pop mem_wdata", mem_wdata, 32'h70);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("starve cleared",     32'(starve),      32'h0);
        check("starve fifo_level",  32'(fifo_level),  32'h0);
        check("starve drain_count", 32'(drain_count), 32'd12);

        // Reset mid-operation with three pending entries.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 32'hA00 + 32'(4 * c), 32'hB0 + 32'(c));
            @(negedge clk);
            check($sformatf("pre-reset c%0d level", c), 32'(fifo_level), 32'(c));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA0C, 32'hBF);
        @(negedge clk);
        check("mid-reset sns_ready", 32'(sns_ready),  32'h0);
        check("mid-reset mem_en",    32'(mem_en),     32'h0);
        check("mid-reset level",     32'(fifo_level), 32'h3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post-reset level",       32'(fifo_level),  32'h0);
        check("post-reset drain_count", 32'(drain_count), 32'h0);
        check("post-reset starve",      32'(starve),      32'h0);
        check("post-reset mem_en",      32'(mem_en),      32'h0);
        check("post-reset sns_ready",   32'(sns_ready),   32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset mem_en 2", 32'(mem_en), 32'h0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("post-reset dmem 0x%03h", 32'hA00 + 32'(4 * c)),
                  dmem[10'h280 + 10'(c)], pre('h280 + c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
